// File: rtl/board_cell_writer.sv
// board_cell_writer: write-side partner of the Cat Trap grid renderer.
// Debounces the centre/down buttons, walks a cursor over the 8x8 board and
// sets "blocked" bits, committing each write only while vblank is high.
// Optional feature: define BOARD_WRITER_PRESET_EN to start with the four
// corner cells (0, 7, 56, 63) blocked after reset and clear.

// Two-flop synchronizer, stable-sample debouncer and rising-edge detector.
module board_cell_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press
);
    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_prev_q, level_prev_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: flip the level only after DB_CYCLES differing samples.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        level_d      = level_q;
        cnt_d        = cnt_q;
        level_prev_d = level_q;
        press_d      = level_q & ~level_prev_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values, independent of statement order.
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

module board_cell_writer #(
    parameter int DB_CYCLES     = 16,
    parameter int CAT_START_IDX = 27
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        BtnC,
    input  logic        BtnD,
    input  logic        vblank,
    input  logic        clear,
    input  logic [5:0]  cat_idx,
    output logic [63:0] blocked,
    output logic [5:0]  cursor_idx,
    output logic        busy,
    output logic        place_ok,
    output logic        place_rej
);
`ifdef BOARD_WRITER_PRESET_EN
    localparam logic [63:0] BASE_PATTERN = 64'h8100_0000_0000_0081;
`else
    localparam logic [63:0] BASE_PATTERN = 64'h0;
`endif
    // The cat's starting cell is never blocked, whatever the preset says.
    localparam logic [63:0] RESET_PATTERN = BASE_PATTERN & ~(64'd1 << CAT_START_IDX);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    logic        press_c, press_d;
    state_t      state_q, state_d;
    logic [63:0] blocked_q, blocked_d;
    logic [5:0]  cursor_q, cursor_d;
    logic [5:0]  tgt_q, tgt_d;
    logic        place_ok_q, place_ok_d;
    logic        place_rej_q, place_rej_d;
    logic        cell_refused;

    board_cell_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_c (
        .clk(clk), .reset_n(reset_n), .btn_raw(BtnC), .press(press_c)
    );
    board_cell_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_d (
        .clk(clk), .reset_n(reset_n), .btn_raw(BtnD), .press(press_d)
    );

    // A placement at the cursor is refused on the cat or on a blocked cell.
    assign cell_refused = (cursor_q == cat_idx) || blocked_q[cursor_q];

    // State register plus board, cursor, target and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            blocked_q   <= RESET_PATTERN;
            cursor_q    <= '0;
            tgt_q       <= '0;
            place_ok_q  <= 1'b0;
            place_rej_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blocked_q   <= blocked_d;
            cursor_q    <= cursor_d;
            tgt_q       <= tgt_d;
            place_ok_q  <= place_ok_d;
            place_rej_q <= place_rej_d;
        end
    end

    // Next state: clear wins; IDLE enters PEND on an acceptable C press,
    // PEND leaves on the first vblank cycle.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (press_c && !cell_refused) state_d = PEND;
                PEND: if (vblank) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs and datapath: cursor stepping, target latch, commit and pulses.
    always_comb begin
        blocked_d   = blocked_q;
        cursor_d    = cursor_q;
        tgt_d       = tgt_q;
        place_ok_d  = 1'b0;
        place_rej_d = 1'b0;
        if (clear) begin
            blocked_d = RESET_PATTERN;
            cursor_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // C uses the pre-increment cursor even when D fires too.
                    if (press_d) cursor_d = cursor_q + 6'd1;
                    if (press_c) begin
                        if (cell_refused) place_rej_d = 1'b1;
                        else              tgt_d       = cursor_q;
                    end
                end
                PEND: begin
                    // Presses are dropped here; the cat may have moved onto
                    // the target since it was latched.
                    if (vblank) begin
                        if (cat_idx == tgt_q) begin
                            place_rej_d = 1'b1;
                        end else begin
                            blocked_d[tgt_q] = 1'b1;
                            place_ok_d       = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign blocked    = blocked_q;
    assign cursor_idx = cursor_q;
    assign busy       = (state_q == PEND);
    assign place_ok   = place_ok_q;
    assign place_rej  = place_rej_q;
endmodule

// File: tb/tb_board_cell_writer.sv
// Directed bench for board_cell_writer with DB_CYCLES=4: debounce, cursor
// wrap, table-driven placements, deferred commit, clear, re-check and reset.
module tb_board_cell_writer;
`ifdef BOARD_WRITER_PRESET_EN
    localparam logic [63:0] PRESET = 64'h8100_0000_0000_0081;
`else
    localparam logic [63:0] PRESET = 64'h0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_c = 1'b0;
    logic        btn_d = 1'b0;
    logic        vblank = 1'b0;
    logic        clear = 1'b0;
    logic [5:0]  cat_idx = 6'd27;
    logic [63:0] blocked;
    logic [5:0]  cursor_idx;
    logic        busy;
    logic        place_ok;
    logic        place_rej;

    int n_cmp = 0;
    int n_fail = 0;
    int ok_cnt = 0;
    int rej_cnt = 0;
    int pc_cnt = 0;

    typedef struct {
        int          steps;
        logic [5:0]  cat;
        logic [5:0]  exp_cursor;
        logic        exp_ok;
        logic        exp_rej;
        logic [63:0] exp_blk;
    } vec_t;
    vec_t vecs[7];

    board_cell_writer #(.DB_CYCLES(4), .CAT_START_IDX(27)) dut (
        .clk(clk), .reset_n(reset_n), .BtnC(btn_c), .BtnD(btn_d),
        .vblank(vblank), .clear(clear), .cat_idx(cat_idx),
        .blocked(blocked), .cursor_idx(cursor_idx), .busy(busy),
        .place_ok(place_ok), .place_rej(place_rej)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (place_ok)            ok_cnt  <= ok_cnt + 1;
        if (place_rej)           rej_cnt <= rej_cnt + 1;
        if (dut.u_deb_c.press_q) pc_cnt  <= pc_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: hold long enough to debounce, then release and settle.
    task automatic press(input logic c, input logic d);
        btn_c = c;
        btn_d = d;
        tick(12);
        btn_c = 1'b0;
        btn_d = 1'b0;
        tick(12);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        int first;
        int ok0, rej0, pc0;
        logic [63:0] exp_blk;

        vecs[0] = '{9,  6'd27, 6'd9,  1'b1, 1'b0, (64'd1 << 9)};
        vecs[1] = '{0,  6'd27, 6'd9,  1'b0, 1'b1, (64'd1 << 9)};
        vecs[2] = '{18, 6'd27, 6'd27, 1'b0, 1'b1, (64'd1 << 9)};
        vecs[3] = '{1,  6'd27, 6'd28, 1'b1, 1'b0, (64'd1 << 9) | (64'd1 << 28)};
        vecs[4] = '{0,  6'd28, 6'd28, 1'b0, 1'b1, (64'd1 << 9) | (64'd1 << 28)};
        vecs[5] = '{34, 6'd27, 6'd62, 1'b1, 1'b0, (64'd1 << 9) | (64'd1 << 28) | (64'd1 << 62)};
        vecs[6] = '{3,  6'd27, 6'd1,  1'b1, 1'b0, (64'd1 << 1) | (64'd1 << 9) | (64'd1 << 28) | (64'd1 << 62)};

        // Reset values.
        tick(3);
        check("rst_blocked", blocked, PRESET);
        check("rst_cursor", 64'(cursor_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ok", 64'(place_ok), 64'd0);
        check("rst_rej", 64'(place_rej), 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Debounce: 2-cycle toggling never debounces; the hold gives one pulse
        // 7 cycles after its rising edge. cat on cell 0 makes it a refusal.
        cat_idx = 6'd0;
        rej0 = rej_cnt;
        pc0 = pc_cnt;
        for (int k = 0; k < 10; k++) begin
            btn_c = (k % 2 == 0);
            tick(2);
        end
        check("deb_toggle_no_press", 64'(pc_cnt - pc0), 64'd0);
        btn_c = 1'b1;
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            tick(1);
            if (dut.u_deb_c.press_q && first == 0) first = n;
        end
        check("deb_latency", 64'(first), 64'd7);
        tick(20);
        check("deb_single_pulse", 64'(pc_cnt - pc0), 64'd1);
        check("deb_rej_on_cat", 64'(rej_cnt - rej0), 64'd1);
        check("deb_busy", 64'(busy), 64'd0);
        btn_c = 1'b0;
        tick(12);
        cat_idx = 6'd27;

        // Cursor wrap over 64 presses.
        for (int i = 0; i < 64; i++) begin
            press(1'b0, 1'b1);
            check($sformatf("wrap_%0d", i), 64'(cursor_idx), 64'((i + 1) % 64));
        end

        // C and D together: C acts on cell 0, cursor still advances.
        vblank = 1'b1;
        ok0 = ok_cnt;
        rej0 = rej_cnt;
        press(1'b1, 1'b1);
        check("both_cursor", 64'(cursor_idx), 64'd1);
        check("both_blocked", blocked, PRESET | 64'd1);
        check("both_ok", 64'(ok_cnt - ok0), PRESET[0] ? 64'd0 : 64'd1);
        check("both_rej", 64'(rej_cnt - rej0), PRESET[0] ? 64'd1 : 64'd0);
        clear_pulse();
        check("clr_idle_blocked", blocked, PRESET);
        check("clr_idle_cursor", 64'(cursor_idx), 64'd0);
        check("clr_idle_ok", 64'(place_ok | place_rej), 64'd0);

        // Table of placements with vblank held high.
        for (int v = 0; v < 7; v++) begin
            cat_idx = vecs[v].cat;
            repeat (vecs[v].steps) press(1'b0, 1'b1);
            ok0 = ok_cnt;
            rej0 = rej_cnt;
            press(1'b1, 1'b0);
            check($sformatf("vec%0d_cursor", v), 64'(cursor_idx), 64'(vecs[v].exp_cursor));
            check($sformatf("vec%0d_ok", v), 64'(ok_cnt - ok0), 64'(vecs[v].exp_ok));
            check($sformatf("vec%0d_rej", v), 64'(rej_cnt - rej0), 64'(vecs[v].exp_rej));
            check($sformatf("vec%0d_blocked", v), blocked, vecs[v].exp_blk | PRESET);
            check($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
        end

        // Deferred commit at cell 5; presses during PEND are dropped.
        vblank = 1'b0;
        cat_idx = 6'd27;
        repeat (4) press(1'b0, 1'b1);
        check("def_cursor", 64'(cursor_idx), 64'd5);
        exp_blk = vecs[6].exp_blk | PRESET;
        ok0 = ok_cnt;
        rej0 = rej_cnt;
        press(1'b1, 1'b0);
        check("def_busy", 64'(busy), 64'd1);
        tick(100);
        check("def_blocked_held", blocked, exp_blk);
        check("def_busy_held", 64'(busy), 64'd1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("def_cursor_dropped", 64'(cursor_idx), 64'd5);
        vblank = 1'b1;
        tick(1);
        check("def_ok_pulse", 64'(place_ok), 64'd1);
        check("def_blocked", blocked, exp_blk | (64'd1 << 5));
        check("def_busy_done", 64'(busy), 64'd0);
        tick(10);
        check("def_one_write", 64'(ok_cnt - ok0), 64'd1);
        check("def_no_rej", 64'(rej_cnt - rej0), 64'd0);
        check("def_no_requeue", 64'(busy), 64'd0);
        vblank = 1'b0;

        // clear while PEND at cell 12.
        repeat (7) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("clr_pend_busy", 64'(busy), 64'd1);
        clear_pulse();
        check("clr_pend_blocked", blocked, PRESET);
        check("clr_pend_cursor", 64'(cursor_idx), 64'd0);
        check("clr_pend_busy0", 64'(busy), 64'd0);
        ok0 = ok_cnt;
        vblank = 1'b1;
        tick(5);
        check("clr_pend_no_ok", 64'(ok_cnt - ok0), 64'd0);
        check("clr_pend_blocked2", blocked, PRESET);
        vblank = 1'b0;

        // Commit-time re-check: cat moves onto target 13.
        repeat (13) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("rchk_busy", 64'(busy), 64'd1);
        cat_idx = 6'd13;
        vblank = 1'b1;
        tick(1);
        check("rchk_rej", 64'(place_rej), 64'd1);
        check("rchk_ok", 64'(place_ok), 64'd0);
        tick(3);
        check("rchk_blocked", blocked, PRESET);
        check("rchk_busy0", 64'(busy), 64'd0);
        cat_idx = 6'd27;

        // Async reset mid-PEND.
        press(1'b1, 1'b0);
        check("ar_setup_blocked", blocked, PRESET | (64'd1 << 13));
        vblank = 1'b0;
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("ar_busy", 64'(busy), 64'd1);
        ok0 = ok_cnt;
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("ar_blocked", blocked, PRESET);
        check("ar_cursor", 64'(cursor_idx), 64'd0);
        check("ar_busy0", 64'(busy), 64'd0);
        check("ar_pulses", 64'(place_ok | place_rej), 64'd0);
        #4 reset_n = 1'b1;
        tick(1);
        vblank = 1'b1;
        tick(5);
        check("ar_no_ok", 64'(ok_cnt - ok0), 64'd0);
        check("ar_blocked2", blocked, PRESET);

`ifdef BOARD_WRITER_PRESET_EN
        // Preset corner cell refuses placement.
        rej0 = rej_cnt;
        press(1'b1, 1'b0);
        check("preset_rej", 64'(rej_cnt - rej0), 64'd1);
        check("preset_blocked", blocked, PRESET);
`endif
        vblank = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
